// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU run controller and its switch debouncer.
package cpu_pkg;

    localparam int unsigned DEFAULT_PC_WIDTH = 8;
    localparam int unsigned RUN_STATE_W      = 3;
    localparam int unsigned COUNT_W          = 8;

    typedef enum logic [RUN_STATE_W-1:0] {
        RESET_HOLD = 3'd0,
        RUN        = 3'd1,
        HALT       = 3'd2,
        STEP       = 3'd3,
        BREAK      = 3'd4
    } run_state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the clean output
// follows the synchronised switch only after DEBOUNCE_CYCLES mismatched cycles.
module switch_debouncer
    import cpu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic isResetN,
    input  logic rawIn,
    output logic cleanOut
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(DEBOUNCE_CYCLES - 1);

    logic               sync_meta;
    logic               sync_out;
    logic [COUNT_W-1:0] count;

    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= rawIn;
            sync_out  <= sync_meta;
        end
    end

    // Any cycle where the synchronised switch agrees with the output restarts the run.
    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            count    <= '0;
            cleanOut <= 1'b0;
        end else if (sync_out != cleanOut) begin
            if (count == LAST_COUNT) begin
                cleanOut <= ~cleanOut;
                count    <= '0;
            end else begin
                count <= count + COUNT_W'(1);
            end
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/halt/step/breakpoint sequencer for the single-cycle CPU: owns CPU reset,
// decodes the CPU clock-enable and debounces the board switch.
module cpu_run_controller
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH          = DEFAULT_PC_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned RESET_HOLD_CYCLES = 4,
    parameter bit          START_RUNNING     = 1'b1
) (
    input  logic                   clock,
    input  logic                   isResetN,
    input  logic                   switch,
    input  logic                   resetRequest,
    input  logic                   haltRequest,
    input  logic                   runRequest,
    input  logic                   stepRequest,
    input  logic                   breakEnable,
    input  logic [PC_WIDTH-1:0]    breakAddress,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   cpuReset,
    output logic                   cpuEnable,
    output logic                   switchClean,
    output logic [RUN_STATE_W-1:0] runState,
    output logic                   isHalted
);

    localparam logic [COUNT_W-1:0] HOLD_LAST = COUNT_W'(RESET_HOLD_CYCLES - 1);

    run_state_t         state;
    run_state_t         next_state;
    logic [COUNT_W-1:0] hold_count;
    logic [COUNT_W-1:0] next_hold;
    logic               skip_break;
    logic               bp_hit;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock   (clock),
        .isResetN(isResetN),
        .rawIn   (switch),
        .cleanOut(switchClean)
    );

    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            state      <= RESET_HOLD;
            hold_count <= '0;
            cpuReset   <= 1'b1;
            skip_break <= 1'b0;
        end else begin
            state      <= next_state;
            hold_count <= next_hold;
            cpuReset   <= (next_state == RESET_HOLD);
            // Resuming from a breakpoint must not re-trigger on the same pc.
            skip_break <= (state == BREAK) && (next_state == RUN);
        end
    end

    always_comb begin
        next_state = state;
        next_hold  = '0;
        cpuEnable  = 1'b0;
        bp_hit     = breakEnable && (pc == breakAddress) && !skip_break;

        case (state)
            RESET_HOLD: begin
                if (hold_count == HOLD_LAST) begin
                    if (START_RUNNING) next_state = RUN;
                    else               next_state = HALT;
                end else begin
                    next_hold = hold_count + COUNT_W'(1);
                end
            end
            RUN: begin
                cpuEnable = !bp_hit;
                if (haltRequest) next_state = HALT;
                else if (bp_hit) next_state = BREAK;
            end
            HALT, BREAK: begin
                if (haltRequest)      next_state = HALT;
                else if (stepRequest) next_state = STEP;
                else if (runRequest)  next_state = RUN;
            end
            STEP: begin
                cpuEnable  = 1'b1;
                next_state = HALT;
            end
            default: next_state = RESET_HOLD;
        endcase

        if (resetRequest) begin
            next_state = RESET_HOLD;
            next_hold  = '0;
        end
    end

    assign runState = state;
    assign isHalted = (state == HALT) || (state == BREAK);

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: a flag-based behavioural model
// predicts every cycle's outputs, a monitor compares them on the falling edge.
module tb_cpu_run_controller;

    localparam int PCW   = 8;
    localparam int DEB   = 4;
    localparam int HOLD  = 4;
    localparam bit START = 1'b1;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       clean;
        logic [2:0] st;
        logic       halted;
    } obs_t;

    logic           clock = 1'b0;
    logic           isResetN = 1'b0;
    logic           switch = 1'b0;
    logic           resetRequest = 1'b0;
    logic           haltRequest = 1'b0;
    logic           runRequest = 1'b0;
    logic           stepRequest = 1'b0;
    logic           breakEnable = 1'b0;
    logic [PCW-1:0] breakAddress = '0;
    logic [PCW-1:0] pc = '0;
    logic           cpuReset;
    logic           cpuEnable;
    logic           switchClean;
    logic [2:0]     runState;
    logic           isHalted;

    cpu_run_controller #(
        .PC_WIDTH(PCW),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_HOLD_CYCLES(HOLD),
        .START_RUNNING(START)
    ) dut (
        .clock(clock),
        .isResetN(isResetN),
        .switch(switch),
        .resetRequest(resetRequest),
        .haltRequest(haltRequest),
        .runRequest(runRequest),
        .stepRequest(stepRequest),
        .breakEnable(breakEnable),
        .breakAddress(breakAddress),
        .pc(pc),
        .cpuReset(cpuReset),
        .cpuEnable(cpuEnable),
        .switchClean(switchClean),
        .runState(runState),
        .isHalted(isHalted)
    );

    always #5 clock = ~clock;

    // Model: remaining reset cycles plus mode flags; the switch is kept as sample history.
    int unsigned    reset_left;
    bit             halted_m, brk_m, step_m, skip_m, clean_m;
    bit             raw_q[$];
    bit             sync_hist[$];
    logic [PCW-1:0] m_pc;
    obs_t           exp_q[$];
    int             n_cmp = 0;
    int             n_err = 0;

    bit             cur_be;
    logic [PCW-1:0] cur_ba;
    bit             cur_sw;

    function automatic void model_reset();
        reset_left = HOLD;
        halted_m = 1'b0; brk_m = 1'b0; step_m = 1'b0; skip_m = 1'b0; clean_m = 1'b0;
        raw_q.delete();
        sync_hist.delete();
        m_pc = '0;
    endfunction

    function automatic bit cur_sync();
        if (raw_q.size() < 2) return 1'b0;
        return raw_q[raw_q.size()-2];
    endfunction

    function automatic bit bp_now();
        return breakEnable && (pc == breakAddress) && !skip_m;
    endfunction

    function automatic bit running();
        return (reset_left == 0) && !halted_m && !brk_m && !step_m;
    endfunction

    function automatic obs_t expect_now();
        obs_t o;
        o.rst    = (reset_left != 0);
        o.en     = step_m || (running() && !bp_now());
        o.clean  = clean_m;
        if (reset_left != 0) o.st = 3'd0;
        else if (step_m)     o.st = 3'd3;
        else if (brk_m)      o.st = 3'd4;
        else if (halted_m)   o.st = 3'd2;
        else                 o.st = 3'd1;
        o.halted = halted_m || brk_m;
        return o;
    endfunction

    // Advance the model across one rising edge using the inputs held during the cycle.
    function automatic void model_edge();
        bit h, all_mis, new_skip;
        int n;
        if (!isResetN) begin
            model_reset();
            return;
        end
        h = bp_now();
        if (reset_left != 0) m_pc = '0;
        else if (step_m || (running() && !h)) m_pc = m_pc + PCW'(1);

        sync_hist.push_back(cur_sync());
        n = sync_hist.size();
        if (n >= DEB) begin
            all_mis = 1'b1;
            for (int i = 0; i < DEB; i++)
                if (sync_hist[n-1-i] == clean_m) all_mis = 1'b0;
            if (all_mis) clean_m = !clean_m;
        end
        if (n > 32) void'(sync_hist.pop_front());
        raw_q.push_back(switch);
        if (raw_q.size() > 4) void'(raw_q.pop_front());

        new_skip = 1'b0;
        if (resetRequest) begin
            reset_left = HOLD;
            halted_m = 1'b0; brk_m = 1'b0; step_m = 1'b0;
        end else if (reset_left != 0) begin
            reset_left = reset_left - 1;
            if (reset_left == 0) halted_m = !START;
        end else if (step_m) begin
            step_m = 1'b0;
            halted_m = 1'b1;
        end else if (!halted_m && !brk_m) begin
            if (haltRequest) halted_m = 1'b1;
            else if (h)      brk_m = 1'b1;
        end else begin
            if (haltRequest) begin
                halted_m = 1'b1; brk_m = 1'b0;
            end else if (stepRequest) begin
                step_m = 1'b1; halted_m = 1'b0; brk_m = 1'b0;
            end else if (runRequest) begin
                new_skip = brk_m; halted_m = 1'b0; brk_m = 1'b0;
            end
        end
        skip_m = new_skip;
    endfunction

    task automatic drive(input bit rr, input bit hr, input bit sr, input bit rn,
                         input bit be, input logic [PCW-1:0] ba, input bit sw,
                         input bit rstn);
        @(posedge clock);
        model_edge();
        #1;
        resetRequest = rr;
        haltRequest  = hr;
        stepRequest  = sr;
        runRequest   = rn;
        breakEnable  = be;
        breakAddress = ba;
        switch       = sw;
        isResetN     = rstn;
        if (!rstn) model_reset();
        pc = m_pc;
        exp_q.push_back(expect_now());
    endtask

    task automatic req(input bit rr, input bit hr, input bit sr, input bit rn);
        drive(rr, hr, sr, rn, cur_be, cur_ba, cur_sw, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) req(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            obs_t e, got;
            e   = exp_q.pop_front();
            got = {cpuReset, cpuEnable, switchClean, runState, isHalted};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL outputs @%0t: got rst=%b en=%b clean=%b state=%0d halted=%b, expected rst=%b en=%b clean=%b state=%0d halted=%b",
                         $time, got.rst, got.en, got.clean, got.st, got.halted,
                         e.rst, e.en, e.clean, e.st, e.halted);
            end
        end
    end

    initial begin
        model_reset();
        cur_be = 1'b1; cur_ba = PCW'(5); cur_sw = 1'b0;
        repeat (3) @(posedge clock);

        idle(12);                                     // reset release, run, break at 0x05
        req(1'b0, 1'b0, 1'b0, 1'b1); idle(4);         // resume past the breakpoint
        cur_be = 1'b0;
        req(1'b0, 1'b1, 1'b0, 1'b0); idle(3);         // halt
        repeat (3) begin
            req(1'b0, 1'b0, 1'b1, 1'b0); idle(3);     // single steps, 4 cycles apart
        end
        cur_sw = 1'b1; idle(2); cur_sw = 1'b0; idle(8);  // short glitch
        cur_sw = 1'b1; idle(10);                          // stable edge
        req(1'b0, 1'b0, 1'b0, 1'b1); idle(2);
        req(1'b0, 1'b1, 1'b1, 1'b1); idle(2);         // halt wins over step/run
        req(1'b1, 1'b1, 1'b0, 1'b0); idle(6);         // reset wins over halt
        req(1'b0, 1'b1, 1'b0, 1'b0); idle(1);
        req(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, cur_be, cur_ba, cur_sw, 1'b0);  // async reset in STEP
        idle(8);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) cur_be = !cur_be;
            if ($urandom_range(0, 29) == 0) cur_ba = PCW'($urandom_range(0, 24));
            if ($urandom_range(0, 7) == 0)  cur_sw = !cur_sw;
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15,
                  cur_be, cur_ba, cur_sw, $urandom_range(0, 399) != 0);
        end

        @(negedge clock);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the single-cycle CPU core.
- Owns CPU reset, gates CPU clock-enable (run / halt / single-step / breakpoint), and debounces the board switch before it reaches the core.
- Sits between the board-level inputs and the CPU instance. The core's pc is fed back for breakpoint matching.

Parameters:
- PC_WIDTH, 8, width of the CPU program counter and the breakpoint address.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before switchClean follows the synchronised switch (range 1..255).
- RESET_HOLD_CYCLES, 4, cycles cpuReset is held after entering RESET_HOLD (range 1..255).
- START_RUNNING, 1, 1: RESET_HOLD exits to RUN; 0: RESET_HOLD exits to HALT.

Ports:
- clock, input, 1, single system clock; all state on rising edge.
- isResetN, input, 1, asynchronous active-low reset.
- switch, input, 1, raw asynchronous board switch.
- resetRequest, input, 1, synchronous request to re-reset the CPU.
- haltRequest, input, 1, level; stop the CPU.
- runRequest, input, 1, level; free-run the CPU.
- stepRequest, input, 1, execute exactly one CPU cycle from HALT or BREAK.
- breakEnable, input, 1, arms the breakpoint comparator.
- breakAddress, input, PC_WIDTH, breakpoint pc value.
- pc, input, PC_WIDTH, current CPU program counter.
- cpuReset, output, 1, active-high reset to the CPU (registered).
- cpuEnable, output, 1, CPU clock-enable (combinational decode of state and breakpoint hit).
- switchClean, output, 1, debounced switch (registered).
- runState, output, 3, encoded state for LEDs and debug.
- isHalted, output, 1, high in HALT or BREAK.

Behaviour:
- States, with runState code: RESET_HOLD=0, RUN=1, HALT=2, STEP=3, BREAK=4. Codes 5..7 are unreachable and recover to RESET_HOLD.
- Async reset (isResetN=0):
  - state=RESET_HOLD, holdCount=0, cpuReset=1.
  - sync flops=0, debounce count=0, switchClean=0, skipBreak=0.
  - cpuEnable=0, isHalted=0.
- RESET_HOLD:
  - cpuReset=1 and cpuEnable=0.
  - holdCount increments each cycle.
  - On the cycle holdCount==RESET_HOLD_CYCLES-1, next state is RUN if START_RUNNING else HALT. cpuReset drops on that same edge.
  - cpuReset is high for exactly RESET_HOLD_CYCLES cycles after reset release.
- Request priority, evaluated every cycle:
  - resetRequest outranks everything and moves any state to RESET_HOLD, clearing holdCount.
  - Then haltRequest, then stepRequest, then runRequest.
- Breakpoint hit: bpHit = breakEnable && pc==breakAddress && !skipBreak.
- RUN:
  - cpuEnable = !bpHit.
  - bpHit -> BREAK, so the instruction at breakAddress is not executed.
  - haltRequest -> HALT. cpuEnable stays 1 during the request cycle unless bpHit.
- HALT:
  - cpuEnable=0.
  - stepRequest -> STEP; runRequest -> RUN.
- STEP:
  - cpuEnable=1 for exactly one cycle regardless of bpHit, then -> HALT.
  - A held stepRequest gives one step per two cycles (STEP, HALT, STEP...).
- BREAK:
  - cpuEnable=0; behaves as HALT.
  - runRequest -> RUN with skipBreak=1 for the first RUN cycle, so execution advances past breakAddress. skipBreak clears after that cycle.
  - stepRequest -> STEP.
- isHalted = (state==HALT || state==BREAK).
- Switch path:
  - Two-flop synchroniser to produce switchSync.
  - If switchSync != switchClean, count++; otherwise count=0.
  - When count reaches DEBOUNCE_CYCLES-1 with a mismatch, switchClean toggles and count clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
  - Latency from a stable edge is 2 + DEBOUNCE_CYCLES cycles.
- Reset mid-operation: isResetN low in any state forces the reset values immediately (asynchronously). Release is synchronous to clock in the design above.
- Width rules:
  - Counters are 8 bits; the PC compare is an exact PC_WIDTH equality.
  - The breakpoint is ignored while breakEnable=0, including mid-RUN changes.

Decomposition:
- Shared package cpu_pkg: run_state_t enum (the five codes above), PC_WIDTH default, runState width constant.
- One natural sub-module: switch_debouncer (synchroniser plus counter), parameterised by DEBOUNCE_CYCLES, with ports clock, isResetN, rawIn, cleanOut.
- The state machine stays in cpu_run_controller.

Test Plan:
- Reset release with defaults -> cpuReset high for 4 cycles, then RUN (runState=1) and cpuEnable=1 on cycle 5.
- RUN, breakEnable=1, breakAddress=0x05, pc counting 0..5 -> cpuEnable=0 in the cycle pc==0x05, runState=4 and isHalted=1 next cycle. Then runRequest pulse -> RUN, pc advances to 0x06, and no re-break at 0x05.
- HALT, stepRequest pulsed 3 times spaced 4 cycles apart -> exactly 3 single-cycle cpuEnable pulses; pc advances by 3.
- switch toggled high for 2 cycles then low -> switchClean stays 0. switch held high -> switchClean=1 exactly 6 cycles after the edge.
- haltRequest, stepRequest and runRequest all asserted in RUN -> HALT. resetRequest plus haltRequest together -> RESET_HOLD with cpuReset=1 for 4 cycles.
- isResetN pulsed low mid-STEP -> cpuEnable=0, cpuReset=1 and runState=0 immediately; switchClean=0.
